// File: rtl/fix_ari_mul.sv
// Three-stage pipelined signed fixed-point multiplier: operand regs, product reg, output regs.
// Emits the 2*WIDTH-1 bit product and a floor-rescaled (>> WIDTH/2) WIDTH-bit product.
module fix_ari_mul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data_in1,
    input  logic [WIDTH-1:0]       data_in2,
    output logic [2*WIDTH-2:0]     data_out,
    output logic [WIDTH-1:0]       data_out_round
);

    localparam int unsigned PW = 2 * WIDTH - 1;

    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic [PW-1:0]    r_p2;

    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_round;

    // Sign-extending to PW bits and multiplying modulo 2^PW yields exactly the
    // low PW bits of the signed product, so -2^(W-1) squared wraps as intended.
    always_comb begin
        w_a_ext = {{(WIDTH-1){r_a1[WIDTH-1]}}, r_a1};
        w_b_ext = {{(WIDTH-1){r_b1[WIDTH-1]}}, r_b1};
        w_prod  = w_a_ext * w_b_ext;
    end

    always_comb begin
        w_round = {r_p2[PW-1], r_p2[WIDTH+WIDTH/2-2 : WIDTH/2]};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_a1           <= '0;
            r_b1           <= '0;
            r_p2           <= '0;
            data_out       <= '0;
            data_out_round <= '0;
        end else begin
            r_a1           <= data_in1;
            r_b1           <= data_in2;
            r_p2           <= w_prod;
            data_out       <= r_p2;
            data_out_round <= w_round;
        end
    end

endmodule

// File: tb/tb_fix_ari_mul.sv
// Directed bench for fix_ari_mul (WIDTH=16): scoreboard queue of expected results,
// one entry pushed per driven operand pair and popped after every rising edge.
module tb_fix_ari_mul;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in1;
    logic [15:0] data_in2;
    logic [30:0] data_out;
    logic [15:0] data_out_round;

    int unsigned n_cmp;
    int unsigned n_bad;

    typedef struct {
        logic [30:0] dout;
        logic [15:0] dround;
        string       tag;
    } exp_t;

    exp_t sb[$];

    fix_ari_mul #(.WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in1       (data_in1),
        .data_in2       (data_in2),
        .data_out       (data_out),
        .data_out_round (data_out_round)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push_zeros();
        exp_t e;
        e.dout   = '0;
        e.dround = '0;
        e.tag    = "flush0";
        sb.delete();
        sb.push_back(e);
        sb.push_back(e);
    endtask

    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_out"}, {1'b0, data_out}, {1'b0, e.dout});
            chk({e.tag, "_round"}, {16'h0, data_out_round}, {16'h0, e.dround});
        end
    endtask

    // Drive a pair whose expected results are given as literal constants.
    task automatic cyc_k(input int a, input int b, input int eo, input int er, input string tag);
        exp_t e;
        data_in1 = 16'(a);
        data_in2 = 16'(b);
        e.dout   = 31'(eo);
        e.dround = 16'(er);
        e.tag    = tag;
        sb.push_back(e);
        tick_check();
    endtask

    // Drive a pair whose expected results come from integer arithmetic.
    task automatic cyc_m(input int a, input int b, input string tag);
        longint full;
        longint fl;
        full = longint'(a) * longint'(b);
        fl   = full >>> 8;
        // full always fits in 31 signed bits except the -2^15 squared wrap
        cyc_k(a, b, int'(full), int'(fl), tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b1;
        data_in1 = 16'd1234;
        data_in2 = 16'hFFB3;

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold_out", {1'b0, data_out}, 32'h0);
            chk("rst_hold_round", {16'h0, data_out_round}, 32'h0);
        end

        rst_n = 1'b0;
        push_zeros();

        cyc_k(-100, 10, -1000, -4, "ex_m100x10");
        cyc_k(0, 30, 0, 0, "ex_0x30");
        cyc_k(-3, 7, -21, -1, "neg_pos");
        cyc_k(-5, -6, 30, 0, "neg_neg");
        cyc_k(256, 256, 65536, 256, "p256sq");
        cyc_k(32767, 32767, 1073676289, 32'h7F00, "maxsq");
        cyc_k(-32768, 32767, -1073709056, 32'h8080, "min_max");
        cyc_k(-32768, -32768, 32'h40000000, 32'h8000, "minsq_wrap");
        cyc_k(1, 255, 255, 0, "trunc_255");
        cyc_k(-1, 1, -1, -1, "floor_m1");

        for (int k = 0; k < 100; k++) begin
            cyc_m(-100 + 10 * k, 10 + 2 * k, $sformatf("stream%0d", k));
        end

        // Three distinct products in flight, then an async reset between edges.
        cyc_m(1111, 2222, "pre_a");
        cyc_m(-3333, 444, "pre_b");
        cyc_m(5555, -666, "pre_c");
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_clr_out", {1'b0, data_out}, 32'h0);
        chk("async_clr_round", {16'h0, data_out_round}, 32'h0);
        data_in1 = 16'd999;
        data_in2 = 16'd999;
        @(posedge clk);
        #1;
        chk("rst_mid_out", {1'b0, data_out}, 32'h0);
        chk("rst_mid_round", {16'h0, data_out_round}, 32'h0);

        rst_n = 1'b0;
        push_zeros();
        cyc_m(7, 9, "post_a");
        cyc_m(-300, 200, "post_b");
        cyc_m(12345, -2, "post_c");
        cyc_m(0, 0, "drain_a");
        cyc_m(0, 0, "drain_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
